// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: two-source frame arbiter for one GMII transmit path.
// Emits preamble/SFD, streams, pads, truncates and spaces frames.
//
// Ports:
//   clk, rst               125 MHz clock, synchronous active-high reset
//   host_req_i/data/last   host egress FIFO (FWFT); host_rd_o pops a byte
//   ptp_req_i/data/last    PTP probe generator (FWFT); ptp_rd_o pops a byte
//   gmii_data_o/en/er      registered GMII TXD / TX_EN / TX_ER
//   busy_o                 high outside IDLE
//   cnt_frame_o            frames started (at SFD), wrapping
//   cnt_trunc_o            frames truncated at MAX_LEN, saturating
//
// Build option: define PTP_STRICT_PRIO_EN to let PTP always win a tie
// instead of round-robin.

module gmii_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req_i,
  input  logic [7:0]  host_data_i,
  input  logic        host_last_i,
  output logic        host_rd_o,
  input  logic        ptp_req_i,
  input  logic [7:0]  ptp_data_i,
  input  logic        ptp_last_i,
  output logic        ptp_rd_o,
  output logic [7:0]  gmii_data_o,
  output logic        gmii_en_o,
  output logic        gmii_er_o,
  output logic        busy_o,
  output logic [31:0] cnt_frame_o,
  output logic [15:0] cnt_trunc_o
);

  localparam int CMAX = (IFG_CYCLES > 7) ? IFG_CYCLES : 7;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [10:0]   bcnt, bcnt_n;
  logic [11:0]   bnext;
  logic          gnt_ptp, gnt_n;
  logic          last_ptp, last_n;
  logic          pick_ptp;
  logic [7:0]    data_n;
  logic          en_n, er_n;
  logic          frame_inc, trunc_inc;
  logic [7:0]    src_data;
  logic          src_last;
  logic          pop;

  assign src_data  = gnt_ptp ? ptp_data_i : host_data_i;
  assign src_last  = gnt_ptp ? ptp_last_i : host_last_i;
  assign bnext     = {1'b0, bcnt} + 12'd1;
  assign pop       = (state == S_DATA) || (state == S_DRAIN);
  assign host_rd_o = pop & ~gnt_ptp;
  assign ptp_rd_o  = pop & gnt_ptp;
  assign busy_o    = (state != S_IDLE);

  always_comb begin
    pick_ptp = 1'b0;
`ifdef PTP_STRICT_PRIO_EN
    pick_ptp = ptp_req_i;
`else
    unique case (1'b1)
      (ptp_req_i & ~host_req_i): pick_ptp = 1'b1;
      (host_req_i & ~ptp_req_i): pick_ptp = 1'b0;
      default:                   pick_ptp = ~last_ptp;
    endcase
`endif
  end

  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    bcnt_n    = bcnt;
    gnt_n     = gnt_ptp;
    last_n    = last_ptp;
    data_n    = 8'h00;
    en_n      = 1'b0;
    er_n      = 1'b0;
    frame_inc = 1'b0;
    trunc_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        cyc_n = '0;
        if (host_req_i || ptp_req_i) begin
          gnt_n   = pick_ptp;
          last_n  = pick_ptp;
          state_n = S_PRE;
        end
      end
      S_PRE: begin
        data_n = 8'h55;
        en_n   = 1'b1;
        cyc_n  = cyc + 1'b1;
        if (cyc == CW'(6)) begin
          cyc_n   = '0;
          state_n = S_SFD;
        end
      end
      S_SFD: begin
        data_n    = 8'hD5;
        en_n      = 1'b1;
        bcnt_n    = '0;
        frame_inc = 1'b1;
        state_n   = S_DATA;
      end
      S_DATA: begin
        cyc_n  = '0;
        data_n = src_data;
        en_n   = 1'b1;
        bcnt_n = bnext[10:0];
        if (src_last) begin
          // short frames finish through the zero pad
          if (bnext < 12'(MIN_LEN)) state_n = S_PAD;
          else                      state_n = S_IFG;
        end else if (bnext == 12'(MAX_LEN)) begin
          er_n      = 1'b1;
          trunc_inc = 1'b1;
          state_n   = S_DRAIN;
        end
      end
      S_PAD: begin
        cyc_n  = '0;
        en_n   = 1'b1;
        bcnt_n = bnext[10:0];
        if (bnext == 12'(MIN_LEN)) state_n = S_IFG;
      end
      S_DRAIN: begin
        // discard the rest of a truncated frame
        cyc_n = '0;
        if (src_last) state_n = S_IFG;
      end
      S_IFG: begin
        cyc_n = cyc + 1'b1;
        if (cyc == CW'(IFG_CYCLES - 1)) begin
          cyc_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cyc         <= '0;
      bcnt        <= '0;
      gnt_ptp     <= 1'b0;
      last_ptp    <= 1'b0;
      gmii_data_o <= 8'h00;
      gmii_en_o   <= 1'b0;
      gmii_er_o   <= 1'b0;
      cnt_frame_o <= '0;
      cnt_trunc_o <= '0;
    end else begin
      state       <= state_n;
      cyc         <= cyc_n;
      bcnt        <= bcnt_n;
      gnt_ptp     <= gnt_n;
      last_ptp    <= last_n;
      gmii_data_o <= data_n;
      gmii_en_o   <= en_n;
      gmii_er_o   <= er_n;
      cnt_frame_o <= cnt_frame_o + {31'd0, frame_inc};
      if (trunc_inc && (cnt_trunc_o != 16'hFFFF))
        cnt_trunc_o <= cnt_trunc_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter: directed self-checking bench for gmii_tx_arbiter.
// Queue-backed FWFT sources feed the DUT; a monitor logs GMII frames.

module tb_gmii_tx_arbiter;

  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req_i = 1'b0;
  logic [7:0]  host_data_i = 8'h00;
  logic        host_last_i = 1'b0;
  logic        host_rd_o;
  logic        ptp_req_i = 1'b0;
  logic [7:0]  ptp_data_i = 8'h00;
  logic        ptp_last_i = 1'b0;
  logic        ptp_rd_o;
  logic [7:0]  gmii_data_o;
  logic        gmii_en_o;
  logic        gmii_er_o;
  logic        busy_o;
  logic [31:0] cnt_frame_o;
  logic [15:0] cnt_trunc_o;

  gmii_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .host_req_i(host_req_i), .host_data_i(host_data_i),
    .host_last_i(host_last_i), .host_rd_o(host_rd_o),
    .ptp_req_i(ptp_req_i), .ptp_data_i(ptp_data_i),
    .ptp_last_i(ptp_last_i), .ptp_rd_o(ptp_rd_o),
    .gmii_data_o(gmii_data_o), .gmii_en_o(gmii_en_o),
    .gmii_er_o(gmii_er_o), .busy_o(busy_o),
    .cnt_frame_o(cnt_frame_o), .cnt_trunc_o(cnt_trunc_o)
  );

  always #4 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // sources
  logic [7:0] hq[$];
  logic       hl[$];
  logic [7:0] pq[$];
  logic       pl[$];
  logic       h_pend = 1'b0;
  logic       p_pend = 1'b0;

  function automatic void drive_src();
    host_req_i  = (hq.size() != 0);
    host_data_i = (hq.size() != 0) ? hq[0] : 8'h00;
    host_last_i = (hl.size() != 0) ? hl[0] : 1'b0;
    ptp_req_i   = (pq.size() != 0);
    ptp_data_i  = (pq.size() != 0) ? pq[0] : 8'h00;
    ptp_last_i  = (pl.size() != 0) ? pl[0] : 1'b0;
  endfunction

  task automatic push_frame(input bit is_ptp, input int len,
                            input logic [7:0] tag);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = (i == 0) ? tag : i[7:0];
      if (is_ptp) begin
        pq.push_back(b);
        pl.push_back(i == len - 1);
      end else begin
        hq.push_back(b);
        hl.push_back(i == len - 1);
      end
    end
    drive_src();
  endtask

  always @(negedge clk) begin
    if (h_pend && hq.size() != 0) begin
      void'(hq.pop_front());
      void'(hl.pop_front());
    end
    if (p_pend && pq.size() != 0) begin
      void'(pq.pop_front());
      void'(pl.pop_front());
    end
    h_pend = host_rd_o;
    p_pend = ptp_rd_o;
    drive_src();
  end

  // monitor
  logic [7:0] cur[$];
  logic [7:0] last_fr[$];
  int         lens[$];
  logic [7:0] tags[$];
  int         gaps[$];
  int         n_done = 0;
  int         low_run = 0;
  int         er_cnt = 0;
  int         er_idx = -1;
  int         h_rd_cnt = 0;
  int         p_rd_cnt = 0;
  logic       en_q = 1'b0;

  always @(negedge clk) begin
    if (host_rd_o) h_rd_cnt++;
    if (ptp_rd_o)  p_rd_cnt++;
    if (gmii_er_o) er_cnt++;
    if (gmii_en_o) begin
      if (!en_q) begin
        gaps.push_back(low_run);
        cur.delete();
      end
      cur.push_back(gmii_data_o);
      if (gmii_er_o) er_idx = cur.size() - 1;
      low_run = 0;
    end else begin
      if (en_q) begin
        last_fr = cur;
        lens.push_back(cur.size());
        tags.push_back(cur.size() > 8 ? cur[8] : 8'h00);
        n_done++;
      end
      low_run++;
    end
    en_q = gmii_en_o;
  end

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (gmii_en_o !== 1'b0) $display("FAIL rst_en: got %0b want 0", gmii_en_o);
    else n_pass++;
    n_chk++;
    if (gmii_data_o !== 8'h00) $display("FAIL rst_data: got %0h want 0", gmii_data_o);
    else n_pass++;
    n_chk++;
    if (gmii_er_o !== 1'b0) $display("FAIL rst_er: got %0b want 0", gmii_er_o);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_o);
    else n_pass++;
    n_chk++;
    if (host_rd_o !== 1'b0) $display("FAIL rst_hrd: got %0b want 0", host_rd_o);
    else n_pass++;
    n_chk++;
    if (ptp_rd_o !== 1'b0) $display("FAIL rst_prd: got %0b want 0", ptp_rd_o);
    else n_pass++;
    n_chk++;
    if (cnt_frame_o !== 32'd0) $display("FAIL rst_cnt_frame: got %0d want 0", cnt_frame_o);
    else n_pass++;
    n_chk++;
    if (cnt_trunc_o !== 16'd0) $display("FAIL rst_cnt_trunc: got %0d want 0", cnt_trunc_o);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_host_frame();
    int d0, h0, e0, n, bad;
    bit ok;
    d0 = n_done; h0 = h_rd_cnt; e0 = er_cnt;
    @(negedge clk);
    push_frame(1'b0, 64, 8'hA1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gmii_en_o && n < 20);
    n_chk++;
    if (n !== 2 || gmii_data_o !== 8'h55)
      $display("FAIL host_latency: got %0d cyc data %0h want 2 cyc data 55", n, gmii_data_o);
    else n_pass++;
    wait_done(d0 + 1, 200, ok);
    n_chk++;
    if (!ok) begin
      $display("FAIL host_timeout: got no frame want 1 frame");
      return;
    end
    n_pass++;
    n_chk++;
    if (lens[d0] !== 72) $display("FAIL host_len: got %0d want 72", lens[d0]);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 7; i++) if (last_fr[i] !== 8'h55) bad++;
    if (last_fr[7] !== 8'hD5) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL host_preamble: got %0d bad bytes want 0", bad);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = (i == 0) ? 8'hA1 : i[7:0];
      if (last_fr[8 + i] !== e) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL host_data: got %0d bad bytes want 0", bad);
    else n_pass++;
    n_chk++;
    if (h_rd_cnt - h0 !== 64) $display("FAIL host_rd_cycles: got %0d want 64", h_rd_cnt - h0);
    else n_pass++;
    n_chk++;
    if (cnt_frame_o !== 32'd1) $display("FAIL host_cnt_frame: got %0d want 1", cnt_frame_o);
    else n_pass++;
    n_chk++;
    if (er_cnt - e0 !== 0) $display("FAIL host_er: got %0d want 0", er_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_ptp_pad();
    int d0, p0, e0, bad;
    bit ok;
    d0 = n_done; p0 = p_rd_cnt; e0 = er_cnt;
    @(negedge clk);
    push_frame(1'b1, 20, 8'hB1);
    wait_done(d0 + 1, 200, ok);
    n_chk++;
    if (!ok) begin
      $display("FAIL ptp_timeout: got no frame want 1 frame");
      return;
    end
    n_pass++;
    n_chk++;
    if (lens[d0] !== 68) $display("FAIL ptp_len: got %0d want 68", lens[d0]);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] e;
      e = (i == 0) ? 8'hB1 : i[7:0];
      if (last_fr[8 + i] !== e) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL ptp_data: got %0d bad bytes want 0", bad);
    else n_pass++;
    bad = 0;
    for (int i = 28; i < 68; i++) if (last_fr[i] !== 8'h00) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL ptp_pad: got %0d nonzero pad bytes want 0", bad);
    else n_pass++;
    n_chk++;
    if (er_cnt - e0 !== 0) $display("FAIL ptp_er: got %0d want 0", er_cnt - e0);
    else n_pass++;
    n_chk++;
    if (p_rd_cnt - p0 !== 20) $display("FAIL ptp_rd_cycles: got %0d want 20", p_rd_cnt - p0);
    else n_pass++;
    n_chk++;
    if (cnt_frame_o !== 32'd2) $display("FAIL ptp_cnt_frame: got %0d want 2", cnt_frame_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, g0;
    bit ok;
    logic [7:0] exp_tag [4];
`ifdef PTP_STRICT_PRIO_EN
    exp_tag = '{8'hB2, 8'hB3, 8'hA2, 8'hA3};
`else
    exp_tag = '{8'hB2, 8'hA2, 8'hB3, 8'hA3};
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    d0 = n_done; g0 = gaps.size();
    push_frame(1'b0, 61, 8'hA2);
    push_frame(1'b0, 61, 8'hA3);
    push_frame(1'b1, 61, 8'hB2);
    push_frame(1'b1, 61, 8'hB3);
    wait_done(d0 + 4, 1000, ok);
    n_chk++;
    if (!ok) begin
      $display("FAIL b2b_timeout: got %0d frames want 4", n_done - d0);
      return;
    end
    n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (tags[d0 + i] !== exp_tag[i])
        $display("FAIL b2b_order%0d: got %0h want %0h", i, tags[d0 + i], exp_tag[i]);
      else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (gaps[g0 + i] !== IFG + 1)
        $display("FAIL b2b_gap%0d: got %0d want %0d", i, gaps[g0 + i], IFG + 1);
      else n_pass++;
    end
    n_chk++;
    if (cnt_frame_o !== 32'd4) $display("FAIL b2b_cnt_frame: got %0d want 4", cnt_frame_o);
    else n_pass++;
  endtask

  task automatic test_truncate();
    int d0, g0, h0, e0, bad;
    bit ok;
    d0 = n_done; g0 = gaps.size(); h0 = h_rd_cnt; e0 = er_cnt;
    @(negedge clk);
    push_frame(1'b0, 1600, 8'hA4);
    push_frame(1'b0, 60, 8'hA5);
    wait_done(d0 + 2, 2500, ok);
    n_chk++;
    if (!ok) begin
      $display("FAIL trunc_timeout: got %0d frames want 2", n_done - d0);
      return;
    end
    n_pass++;
    n_chk++;
    if (lens[d0] !== 1526) $display("FAIL trunc_len: got %0d want 1526", lens[d0]);
    else n_pass++;
    n_chk++;
    if (er_cnt - e0 !== 1) $display("FAIL trunc_er_count: got %0d want 1", er_cnt - e0);
    else n_pass++;
    n_chk++;
    if (er_idx !== 1525) $display("FAIL trunc_er_pos: got %0d want 1525", er_idx);
    else n_pass++;
    n_chk++;
    if (h_rd_cnt - h0 !== 1660) $display("FAIL trunc_rd_cycles: got %0d want 1660", h_rd_cnt - h0);
    else n_pass++;
    n_chk++;
    if (cnt_trunc_o !== 16'd1) $display("FAIL trunc_cnt: got %0d want 1", cnt_trunc_o);
    else n_pass++;
    n_chk++;
    if (gaps[g0 + 1] !== 82 + IFG + 1)
      $display("FAIL trunc_gap: got %0d want %0d", gaps[g0 + 1], 82 + IFG + 1);
    else n_pass++;
    n_chk++;
    if (lens[d0 + 1] !== 68) $display("FAIL trunc_next_len: got %0d want 68", lens[d0 + 1]);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] e;
      e = (i == 0) ? 8'hA5 : i[7:0];
      if (last_fr[8 + i] !== e) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL trunc_next_data: got %0d bad bytes want 0", bad);
    else n_pass++;
    n_chk++;
    if (cnt_frame_o !== 32'd6) $display("FAIL trunc_cnt_frame: got %0d want 6", cnt_frame_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0, n;
    bit ok;
    @(negedge clk);
    push_frame(1'b0, 64, 8'hA6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gmii_en_o && gmii_data_o == 8'hD5) && n < 50);
    n_chk++;
    if (n >= 50) begin
      $display("FAIL midrst_sfd: got no SFD want SFD");
      return;
    end
    n_pass++;
    repeat (30) @(negedge clk);
    n_chk++;
    if (gmii_data_o !== 8'h1D) $display("FAIL midrst_byte30: got %0h want 1d", gmii_data_o);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (gmii_en_o !== 1'b0) $display("FAIL midrst_en: got %0b want 0", gmii_en_o);
    else n_pass++;
    n_chk++;
    if (gmii_data_o !== 8'h00) $display("FAIL midrst_data: got %0h want 0", gmii_data_o);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy_o);
    else n_pass++;
    n_chk++;
    if (cnt_frame_o !== 32'd0) $display("FAIL midrst_cnt: got %0d want 0", cnt_frame_o);
    else n_pass++;
    rst = 1'b0;
    hq.delete(); hl.delete(); pq.delete(); pl.delete();
    drive_src();
    repeat (2) @(negedge clk);
    d0 = n_done;
    push_frame(1'b0, 60, 8'hA7);
    push_frame(1'b1, 60, 8'hB7);
    wait_done(d0 + 1, 200, ok);
    n_chk++;
    if (!ok) begin
      $display("FAIL midrst_timeout: got no frame want 1 frame");
      return;
    end
    n_pass++;
    n_chk++;
    if (tags[d0] !== 8'hB7) $display("FAIL midrst_tie: got %0h want b7", tags[d0]);
    else n_pass++;
  endtask

  initial begin
    drive_src();
    test_reset();
    test_host_frame();
    test_ptp_pad();
    test_back_to_back();
    test_truncate();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
